// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word from instruction memory, hands it
// to the IR, decodes the opcode, and runs an execute handshake before the next fetch.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_load,
    output logic [31:0] ir_data,
    input  logic [31:0] ir_q,
    output logic [5:0]  opcode,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [15:0] instr_count,
    output logic        halt,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_data_q, ir_data_d;
    logic [5:0]    opcode_q, opcode_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          first_q, first_d;
    logic          halt_q, halt_d;
    logic          fault_q, fault_d;

    // Only the opcode field of the IR is inspected here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[25:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_data_q <= '0;
            opcode_q  <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            first_q   <= 1'b0;
            halt_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_data_q <= ir_data_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            first_q   <= first_d;
            halt_q    <= halt_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!stall) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack)
                    state_d = S_LOAD;
                else if (wait_q == WAIT_LAST)
                    state_d = S_FAULT;
            end
            S_LOAD:   state_d = S_DECODE;
            S_DECODE: state_d = (ir_q[31:26] == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC:   if (exec_done) state_d = S_IDLE;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        ir_data_d = ir_data_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        if (state_q == S_FETCH) begin
            if (mem_ack) begin
                ir_data_d = mem_rdata;
                wait_d    = '0;
            end else if (wait_q != WAIT_LAST) begin
                wait_d = wait_q + WW'(1);
            end
        end
        if (state_q == S_DECODE)
            opcode_d = ir_q[31:26];
        if (state_q == S_EXEC && exec_done) begin
            pc_d  = branch_taken ? branch_target : pc_q + 32'd4;
            cnt_d = cnt_q + 16'd1;
        end
        // EXECUTE is only ever entered from DECODE, so this marks its first cycle.
        first_d = (state_q == S_DECODE);
        halt_d  = (state_d == S_HALT);
        fault_d = (state_d == S_FAULT);
    end

    always_comb begin
        mem_req    = (state_q == S_FETCH);
        ir_load    = (state_q == S_LOAD);
        exec_start = (state_q == S_EXEC) && first_q;
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign ir_data     = ir_data_q;
    assign opcode      = opcode_q;
    assign instr_count = cnt_q;
    assign halt        = halt_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a sequencing model is checked every cycle,
// and literal expectations pin the key scenarios.
module tb_fetch_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b1;
    logic        mem_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] branch_target = '0;
    logic [31:0] ir_q;

    logic        mem_req, ir_load, exec_start, halt, fault;
    logic [31:0] mem_addr, ir_data, pc;
    logic [5:0]  opcode;
    logic [15:0] instr_count;
    logic [2:0]  state;

    int n_run = 0;
    int n_fail = 0;
    bit armed = 1'b0;

    fetch_sequencer #(.RESET_PC(32'h0), .HALT_OP(6'h3F), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_load(ir_load), .ir_data(ir_data), .ir_q(ir_q), .opcode(opcode),
        .exec_start(exec_start), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .instr_count(instr_count), .halt(halt), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // The instruction register sitting behind ir_load / ir_data / ir_q.
    always @(posedge clk or negedge reset)
        if (!reset) ir_q <= '0;
        else if (ir_load) ir_q <= ir_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: phase of the instruction life cycle plus architectural values.
    int          m_ph;       // 0 idle,1 fetch,2 load,3 decode,4 exec,5 halt,6 fault
    int          m_wait;
    int          m_exec_cyc; // cycles already spent in exec
    logic [31:0] m_pc, m_ird;
    logic [5:0]  m_op;
    logic [15:0] m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph = 0; m_wait = 0; m_exec_cyc = 0;
            m_pc = 32'h0; m_ird = '0; m_op = '0; m_cnt = '0;
        end else begin
            case (m_ph)
                0: if (!stall) m_ph = 1;
                1: if (mem_ack) begin
                       m_ird = mem_rdata; m_wait = 0; m_ph = 2;
                   end else if (m_wait + 1 >= TO) m_ph = 6;
                   else m_wait = m_wait + 1;
                2: m_ph = 3;
                3: begin
                       m_op = ir_q[31:26];
                       m_ph = (ir_q[31:26] == 6'h3F) ? 5 : 4;
                       m_exec_cyc = 0;
                   end
                4: begin
                       m_exec_cyc = m_exec_cyc + 1;
                       if (exec_done) begin
                           m_pc  = branch_taken ? branch_target : m_pc + 32'd4;
                           m_cnt = m_cnt + 16'd1;
                           m_ph  = 0;
                       end
                   end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m.state",       32'(state),       32'(m_ph));
            chk("m.mem_req",     32'(mem_req),     32'(m_ph == 1));
            chk("m.mem_addr",    mem_addr,         m_pc);
            chk("m.pc",          pc,               m_pc);
            chk("m.ir_load",     32'(ir_load),     32'(m_ph == 2));
            chk("m.ir_data",     ir_data,          m_ird);
            chk("m.opcode",      32'(opcode),      32'(m_op));
            chk("m.exec_start",  32'(exec_start),  32'(m_ph == 4 && m_exec_cyc == 0));
            chk("m.instr_count", 32'(instr_count), 32'(m_cnt));
            chk("m.halt",        32'(halt),        32'(m_ph == 5));
            chk("m.fault",       32'(fault),       32'(m_ph == 6));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        armed = 1'b1;
        chk("rst state", 32'(state), 32'd0);
        chk("rst pc", pc, 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst count", 32'(instr_count), 32'd0);
        chk("rst ir_data", ir_data, 32'd0);

        // First instruction, immediate ack, branch taken to 0x100
        reset = 1'b1; stall = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h100F_0001;
        tick();
        chk("A fetch state", 32'(state), 32'd1);
        chk("A mem_req", 32'(mem_req), 32'd1);
        tick();
        chk("A ir_load", 32'(ir_load), 32'd1);
        chk("A ir_data", ir_data, 32'h100F_0001);
        mem_ack = 1'b0;
        tick();
        chk("A ir_load once", 32'(ir_load), 32'd0);
        tick();
        chk("A exec_start", 32'(exec_start), 32'd1);
        chk("A opcode", 32'(opcode), 32'h04);
        mem_ack = 1'b1;
        tick();
        chk("A exec_start once", 32'(exec_start), 32'd0);
        chk("A ack ignored", 32'(state), 32'd4);
        mem_ack = 1'b0; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h100; stall = 1'b1;
        tick();
        chk("A pc branch", pc, 32'h100);
        chk("A count", 32'(instr_count), 32'd1);
        exec_done = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        chk("A stall idle", 32'(state), 32'd0);
        chk("A stall no req", 32'(mem_req), 32'd0);
        stall = 1'b0;
        tick();
        chk("A next mem_addr", mem_addr, 32'h100);

        // Fetch timeout
        n = 1;
        for (int i = 0; i < 40 && state == 3'd1; i++) begin
            tick();
            if (state == 3'd1) n++;
        end
        chk("T fetch cycles", 32'(n), 32'd16);
        chk("T state", 32'(state), 32'd6);
        chk("T fault", 32'(fault), 32'd1);
        mem_ack = 1'b1; exec_done = 1'b1;
        repeat (3) tick();
        chk("T stays fault", 32'(state), 32'd6);
        chk("T no req", 32'(mem_req), 32'd0);

        // Not-taken execute at pc 0, then a HALT opcode
        mem_ack = 1'b0; exec_done = 1'b0;
        #2 reset = 1'b0;
        tick();
        reset = 1'b1; stall = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A0F_0001;
        tick();
        tick(); mem_ack = 1'b0;
        tick();
        tick();
        chk("B opcode", 32'(opcode), 32'h16);
        exec_done = 1'b1; branch_taken = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFC00_0000;
        tick();
        chk("B pc", pc, 32'h4);
        chk("B count", 32'(instr_count), 32'd1);
        exec_done = 1'b0;
        tick();
        chk("B mem_addr", mem_addr, 32'h4);
        tick(); mem_ack = 1'b0;
        tick();
        tick();
        chk("H state", 32'(state), 32'd5);
        chk("H halt", 32'(halt), 32'd1);
        mem_ack = 1'b1; exec_done = 1'b1;
        repeat (4) tick();
        chk("H stays", 32'(state), 32'd5);
        chk("H no req", 32'(mem_req), 32'd0);
        chk("H count", 32'(instr_count), 32'd1);

        // pc wraps through 0xFFFF_FFFC + 4
        mem_ack = 1'b0; exec_done = 1'b0;
        #2 reset = 1'b0;
        tick();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0400_0000;
        tick();
        tick(); mem_ack = 1'b0;
        tick();
        tick(); exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        chk("W pc target", pc, 32'hFFFF_FFFC);
        exec_done = 1'b0; branch_taken = 1'b0; mem_ack = 1'b1;
        tick();
        tick(); mem_ack = 1'b0;
        tick();
        tick(); exec_done = 1'b1;
        tick();
        chk("W pc wrap", pc, 32'h0);
        chk("W count", 32'(instr_count), 32'd2);

        // Reset during execute, then stall held after release
        exec_done = 1'b0; mem_ack = 1'b1;
        tick();
        tick(); mem_ack = 1'b0;
        tick();
        tick(); exec_done = 1'b1;
        tick();
        chk("R pc before", pc, 32'h4);
        exec_done = 1'b0; mem_ack = 1'b1;
        tick();
        tick(); mem_ack = 1'b0;
        tick();
        tick();
        chk("R exec_start", 32'(exec_start), 32'd1);
        exec_done = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("R exec_start drop", 32'(exec_start), 32'd0);
        chk("R state", 32'(state), 32'd0);
        chk("R pc", pc, 32'h0);
        chk("R count", 32'(instr_count), 32'd0);
        chk("R opcode", 32'(opcode), 32'd0);
        stall = 1'b1; exec_done = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("R stall idle", 32'(state), 32'd0);
        chk("R stall no req", 32'(mem_req), 32'd0);
        stall = 1'b0;
        tick();
        chk("R fetch req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("R req drop", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b1; stall = 1'b1;
        tick();
        chk("R final idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
